// File: rtl/data_sram_resp.sv
// Data-SRAM responder: word RAM with byte strobes, fixed response latency and an in-order queue.
// Optional DATA_SRAM_RESP_STALL_EN adds an LFSR that randomly withholds addr_ok.
module data_sram_resp #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned PtrW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CntW  = $clog2(OUTSTANDING + 1);

  localparam logic [2:0]      LoadCd  = 3'(LATENCY - 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(OUTSTANDING - 1);
  localparam logic [CntW-1:0] Full    = CntW'(OUTSTANDING);

  logic [31:0]           mem [Depth];
  logic [ADDR_WIDTH-1:0] word_idx;

  logic                  ent_wr_q   [OUTSTANDING];
  logic [31:0]           ent_data_q [OUTSTANDING];
  logic [2:0]            ent_cd_q   [OUTSTANDING];
  logic [PtrW-1:0]       head_q;
  logic [PtrW-1:0]       tail_q;
  logic [CntW-1:0]       count_q;

  logic                  accept;
  logic                  retire;
  logic                  stall;
  logic                  unused_addr;

  assign word_idx    = addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Fixed latency and single acceptance per cycle mean the head always expires first.
  assign retire  = (count_q != '0) && (ent_cd_q[head_q] == 3'd0);
  assign addr_ok = resetn && ((count_q < Full) || retire) && !stall;
  assign accept  = req && addr_ok;

  assign data_ok = retire;
  assign rdata   = (retire && !ent_wr_q[head_q]) ? ent_data_q[head_q] : 32'h0;

`ifdef DATA_SRAM_RESP_STALL_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR, taps 8,6,5,4.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        ent_wr_q[i]   <= 1'b0;
        ent_data_q[i] <= 32'h0;
        ent_cd_q[i]   <= 3'd0;
      end
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (ent_cd_q[i] != 3'd0) begin
          ent_cd_q[i] <= ent_cd_q[i] - 3'd1;
        end
      end
      if (accept) begin
        ent_wr_q[tail_q]   <= wr;
        ent_data_q[tail_q] <= wr ? 32'h0 : mem[word_idx];
        ent_cd_q[tail_q]   <= LoadCd;
        tail_q             <= next_ptr(tail_q);
      end
      if (retire) begin
        head_q <= next_ptr(head_q);
      end
      if (accept && !retire) begin
        count_q <= count_q + 1'b1;
      end else if (!accept && retire) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: four configurations checked every cycle against a queue-based model,
// plus a directed vector table and hand sequences for multi-cycle corner cases.
module tb_data_sram_resp;

  localparam int NI = 4;

  typedef struct {
    int          due;
    bit          w;
    bit          known;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    bit          w;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        req    [NI];
  logic        wr     [NI];
  logic [3:0]  wstrb  [NI];
  logic [31:0] addr   [NI];
  logic [31:0] wdata  [NI];
  logic        addr_ok[NI];
  logic        data_ok[NI];
  logic [31:0] rdata  [NI];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] pre [NI][16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef DATA_SRAM_RESP_STALL_EN
  logic [7:0] lf;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) lf <= 8'hA5;
    else         lf <= {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
  end
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 4;
    localparam int O = (g == 3) ? 1 : 2;

    data_sram_resp #(
      .ADDR_WIDTH (10),
      .LATENCY    (L),
      .OUTSTANDING(O)
    ) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .req    (req[g]),
      .wr     (wr[g]),
      .wstrb  (wstrb[g]),
      .addr   (addr[g]),
      .wdata  (wdata[g]),
      .addr_ok(addr_ok[g]),
      .data_ok(data_ok[g]),
      .rdata  (rdata[g])
    );

    // Reference: pending responses with due cycles, byte-wise memory image.
    ent_t        q [$];
    logic [7:0]  mb [int];
    ent_t        ne;
    bit          e_ok, e_aok, e_known;
    logic [31:0] e_rd;
    int          key;

    always @(negedge clk) begin
      e_ok = 0; e_known = 1; e_rd = 32'h0; e_aok = 0;
      if (!resetn) begin
        q.delete();
      end else begin
        if (q.size() != 0) begin
          if (q[0].due == cyc) begin
            e_ok    = 1;
            e_known = q[0].known;
            if (!q[0].w) e_rd = q[0].d;
          end
        end
        e_aok = (q.size() < O) || e_ok;
`ifdef DATA_SRAM_RESP_STALL_EN
        if (lf[0]) e_aok = 0;
`endif
      end
      chk($sformatf("i%0d data_ok c%0d", g, cyc), 32'(data_ok[g]), 32'(e_ok));
      chk($sformatf("i%0d addr_ok c%0d", g, cyc), 32'(addr_ok[g]), 32'(e_aok));
      if (e_known) chk($sformatf("i%0d rdata c%0d", g, cyc), rdata[g], e_rd);
      if (resetn) begin
        if (e_ok) void'(q.pop_front());
        if (req[g] && e_aok) begin
          key      = int'(addr[g][11:2]);
          ne.due   = cyc + L;
          ne.w     = wr[g];
          ne.known = 1;
          ne.d     = 32'h0;
          for (int b = 0; b < 4; b++) begin
            if (wr[g]) begin
              if (wstrb[g][b]) mb[key*4+b] = wdata[g][8*b +: 8];
            end else if (mb.exists(key*4+b)) begin
              ne.d[8*b +: 8] = mb[key*4+b];
            end else begin
              ne.known = 0;
            end
          end
          q.push_back(ne);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int i, input bit w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, output int acc_edge);
    bit done = 0;
    acc_edge = -1000;
    req[i] = 1'b1; wr[i] = w; wstrb[i] = s; addr[i] = a; wdata[i] = d;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      if (addr_ok[i]) begin
        done = 1;
        acc_edge = cyc + 1;
      end
      @(posedge clk);
      #1;
    end
    req[i] = 1'b0;
    chk($sformatf("i%0d accepted", i), 32'(done), 32'd1);
  endtask

  task automatic wait_resp(input int i, output int rcyc, output logic [31:0] rd);
    bit got = 0;
    rcyc = -1;
    rd   = 32'h0;
    for (int t = 0; t < 32 && !got; t++) begin
      @(negedge clk);
      if (data_ok[i]) begin
        got  = 1;
        rcyc = cyc;
        rd   = rdata[i];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_run(input int i, input int n);
    bit          pend = 0;
    bit          acc;
    logic [31:0] r;
    for (int c = 0; c < n + 64 && (c < n || pend); c++) begin
      if (!pend && c < n && $urandom_range(0, 9) < 7) begin
        r        = $urandom();
        wr[i]    = r[0];
        wstrb[i] = r[4:1];
        wdata[i] = $urandom();
        r        = $urandom();
        addr[i]  = (r & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
        req[i]   = 1'b1;
        pend     = 1;
      end
      @(negedge clk);
      acc = req[i] && addr_ok[i];
      @(posedge clk);
      #1;
      if (acc) begin
        req[i] = 1'b0;
        pend   = 0;
      end
    end
    req[i] = 1'b0;
    chk($sformatf("i%0d random drained", i), 32'(pend), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [13];
    int          ae, rc;
    logic [31:0] rd;
    bit          ea [6];
    bit          ed [6];

    tbl[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 32'h0};
    tbl[1]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'h1234_5678};
    tbl[2]  = '{1'b1, 4'h2, 32'h0000_0010, 32'hAABB_CCDD, 32'h0};
    tbl[3]  = '{1'b0, 4'hF, 32'h0000_0010, 32'hFFFF_FFFF, 32'h1234_CC78};
    tbl[4]  = '{1'b1, 4'h8, 32'h0000_1010, 32'h9900_0000, 32'h0};
    tbl[5]  = '{1'b0, 4'h0, 32'h0000_0013, 32'h0,         32'h9934_CC78};
    tbl[6]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1111_1111, 32'h0};
    tbl[7]  = '{1'b1, 4'h0, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0};
    tbl[8]  = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,         32'h1111_1111};
    tbl[9]  = '{1'b1, 4'hF, 32'h0000_0FFC, 32'hDEAD_BEEF, 32'h0};
    tbl[10] = '{1'b0, 4'h0, 32'h0000_7FFC, 32'h0,         32'hDEAD_BEEF};
    tbl[11] = '{1'b1, 4'h1, 32'h0000_0FFC, 32'h0000_00AA, 32'h0};
    tbl[12] = '{1'b0, 4'h0, 32'hF000_0FFE, 32'h0,         32'hDEAD_BEAA};

    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; wstrb[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
    end
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("i%0d reset addr_ok", i), 32'(addr_ok[i]), 32'd0);
      chk($sformatf("i%0d reset data_ok", i), 32'(data_ok[i]), 32'd0);
      chk($sformatf("i%0d reset rdata", i), rdata[i], 32'h0);
    end
    @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NI; i++) begin
      for (int w = 0; w < 16; w++) begin
        pre[i][w] = $urandom();
        do_req(i, 1'b1, 4'hF, 32'(w) << 2, pre[i][w], ae);
      end
    end
    idle(6);

    for (int k = 0; k < 13; k++) begin
      do_req(0, tbl[k].w, tbl[k].strb, tbl[k].addr, tbl[k].wdata, ae);
      wait_resp(0, rc, rd);
      chk($sformatf("tbl%0d rdata", k), rd, tbl[k].exp_rd);
      chk($sformatf("tbl%0d latency", k), 32'(rc - ae), 32'd0);
    end
    idle(4);

`ifndef DATA_SRAM_RESP_STALL_EN
    // Write then read on consecutive cycles, LATENCY=1.
    req[0] = 1'b1; wr[0] = 1'b1; wstrb[0] = 4'hF; addr[0] = 32'h40; wdata[0] = 32'hCAFE_F00D;
    @(negedge clk);
    chk("b2b first addr_ok", 32'(addr_ok[0]), 32'd1);
    @(posedge clk);
    #1 wr[0] = 1'b0;
    @(negedge clk);
    chk("b2b write data_ok", 32'(data_ok[0]), 32'd1);
    chk("b2b write rdata", rdata[0], 32'h0);
    chk("b2b second addr_ok", 32'(addr_ok[0]), 32'd1);
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    chk("b2b read data_ok", 32'(data_ok[0]), 32'd1);
    chk("b2b read rdata", rdata[0], 32'hCAFE_F00D);
    idle(4);

    // LATENCY=3, OUTSTANDING=2: req held for 6 cycles.
    ea = '{1, 1, 0, 1, 1, 0};
    ed = '{0, 0, 0, 1, 1, 0};
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h8;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("l3 addr_ok k%0d", k), 32'(addr_ok[1]), 32'(ea[k]));
      chk($sformatf("l3 data_ok k%0d", k), 32'(data_ok[1]), 32'(ed[k]));
      @(posedge clk);
      #1;
    end
    req[1] = 1'b0;
    for (int k = 6; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("l3 tail data_ok k%0d", k), 32'(data_ok[1]), 32'(k < 8));
      @(posedge clk);
      #1;
    end
    idle(4);

    // LATENCY=2, OUTSTANDING=2: full throughput.
    req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 32'h4;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("l2 addr_ok k%0d", k), 32'(addr_ok[2]), 32'd1);
      chk($sformatf("l2 data_ok k%0d", k), 32'(data_ok[2]), 32'(k >= 2));
      @(posedge clk);
      #1;
    end
    req[2] = 1'b0;
    idle(6);

    // Reset while two reads are pending on the LATENCY=3 instance.
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h4;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 req[1] = 1'b0;
    @(posedge clk);
    #1 chk("rst pre data_ok", 32'(data_ok[1]), 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("rst data_ok", 32'(data_ok[1]), 32'd0);
    chk("rst rdata", rdata[1], 32'h0);
    chk("rst addr_ok", 32'(addr_ok[1]), 32'd0);
    @(posedge clk);
    #2 resetn = 1'b1;
    idle(5);
    do_req(1, 1'b0, 4'h0, 32'h4, 32'h0, ae);
    wait_resp(1, rc, rd);
    chk("rst readback rdata", rd, pre[1][1]);
    chk("rst readback latency", 32'(rc - ae), 32'd2);
    idle(4);
`endif

    for (int i = 0; i < NI; i++) begin
      rand_run(i, 400);
      idle(10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder (slave) end of the data-SRAM interface. The execute stage issues requests on it and the memory stage consumes the read data.
- Word-addressed RAM with byte write strobes and a request/address-accept/data-return handshake.
- Fixed, parameterised response latency; bounded number of outstanding requests; responses strictly in order.
- Serves as the data memory in simulation/SoC and as the model memory-stage benches drive against.

Parameters:
ADDR_WIDTH, 10, word-address bits; memory holds 2**ADDR_WIDTH 32-bit words
LATENCY, 1, cycles from accepting edge to the data_ok cycle; legal range 1..8
OUTSTANDING, 2, maximum accepted-but-unanswered requests; legal range 1..4

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
req  input  1  request valid from initiator
wr  input  1  1 = write, 0 = read
wstrb  input  4  byte enables for writes (bit i -> wdata[8i+7:8i]); ignored on reads
addr  input  32  byte address; word index = addr[ADDR_WIDTH+1:2]; addr[1:0] and upper bits ignored
wdata  input  32  write data
addr_ok  output  1  request accepted this cycle when req && addr_ok
data_ok  output  1  one-cycle response pulse, one per accepted request, in acceptance order
rdata  output  32  read data, valid when data_ok and the responding entry is a read; 32'h0 otherwise

Behaviour:
- Reset (resetn low, asynchronous): pending queue emptied; countdowns cleared; data_ok=0, rdata=0, addr_ok=0 while resetn is low. Memory array is not cleared. Requests in flight at reset are dropped and get no response.
- Acceptance: on an edge where req && addr_ok is high, the request is accepted.
  - Write: memory bytes selected by wstrb are updated at that edge. wstrb=0 still produces a response.
  - Read: the addressed word is sampled at that edge, after any write accepted at the same edge (none possible, one request per cycle). It therefore reflects all earlier accepted writes.
- Queue: FIFO of OUTSTANDING entries. Each entry holds {is_write, data[31:0], countdown}.
  - countdown loads LATENCY-1 at acceptance and decrements each cycle while nonzero.
  - The head entry retires (data_ok=1) in the cycle its countdown is 0.
  - Accepted at edge N -> data_ok high in the cycle following edge N+LATENCY-1. With LATENCY=1 this is the cycle right after acceptance, identical to a synchronous SRAM.
  - One acceptance per cycle plus fixed latency means at most one entry retires per cycle.
  - No response backpressure: the initiator must take data_ok/rdata in that cycle.
- addr_ok = resetn && (count < OUTSTANDING || data_ok). Accept and retire in the same cycle keep count unchanged. With OUTSTANDING >= LATENCY, back-to-back requests are accepted every cycle.
- rdata = head.data when data_ok && !head.is_write, else 32'h0. data_ok and rdata are driven from registered state only; there is no combinational path from req/addr to them.
- count is kept in a register 0..OUTSTANDING: +1 on accept, -1 on retire, unchanged on both.
- Full: with count==OUTSTANDING and no retire, addr_ok=0. The initiator holds req and its fields stable until accepted.
- Out-of-range upper address bits alias: addr 32'h0000_1000 and 32'h0000_0000 hit the same word when ADDR_WIDTH=10.

Optional Feature:
- Macro DATA_SRAM_RESP_STALL_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) resets to 8'hA5 and advances every cycle.
  - addr_ok is additionally forced low in any cycle where lfsr[0]==1.
  - Used to exercise initiator hold/stall paths. Latency of accepted requests is unchanged.
- Undefined: no LFSR; addr_ok is exactly as specified above.

Test Plan:
- Reset, then write addr=32'h10, wdata=32'h1234_5678, wstrb=4'hF, then read addr=32'h10 next cycle (LATENCY=1) -> two data_ok pulses on consecutive cycles; second has rdata=32'h1234_5678; first has rdata=0.
- Partial write wstrb=4'b0010, wdata=32'hAABB_CCDD over word 32'h1234_5678, then read -> rdata=32'h1234_CC78.
- LATENCY=3, OUTSTANDING=2, req held high for 6 cycles (reads) -> addr_ok drops after 2 accepts until first data_ok; each data_ok exactly 3 cycles after its accept edge; order preserved.
- LATENCY=2, OUTSTANDING=2, reads every cycle -> addr_ok stays 1 and data_ok is continuous from cycle 2 on (accept/retire same cycle).
- Assert resetn=0 mid-cycle with 2 reads pending -> data_ok, rdata, addr_ok go 0 immediately; after release no stale data_ok; a previously written word still reads back its value.
- With DATA_SRAM_RESP_STALL_EN, req held continuously -> addr_ok low exactly in cycles with lfsr[0]=1 (first cycle after reset: 8'hA5, bit0=1 -> stalled); all accepted requests respond after LATENCY.
